// File: rtl/ysyx_25020037_axi_rd_slave.sv
// ysyx_25020037_axi_rd_slave: AXI4 read responder (AR/R) in front of a synchronous-read word memory
module ysyx_25020037_axi_rd_slave #(
   parameter logic [31:0] ADDR_BASE = 32'hA0000000,
   parameter logic [31:0] ADDR_SIZE = 32'h02000000,
   parameter int          LATENCY   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, WAIT, FETCH, LOAD, DATA} state_t;
   localparam logic [3:0] LAT_LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
   state_t      state;
   logic [3:0]  wcnt;
   logic [7:0]  beat;
   logic [7:0]  len_q;
   logic [2:0]  size_q;
   logic        fixed_q;
   logic [31:0] cur_addr;
   logic [31:0] nxt_addr;
   logic [32:0] last_byte;
   logic        bad_req;
   logic        dec_err;
   logic        last_beat;
   logic [1:0]  req_resp;
   // 33-bit window check so a burst running past 4 GB cannot wrap back into range
   assign bad_req   = arburst[1] || arsize > 3'd2 || |(araddr[1:0] & ((2'd1 << arsize[1:0]) - 2'd1));
   assign last_byte = {1'b0, araddr} + (arburst[0] ? ({25'd0, arlen} + 33'd1) << arsize : 33'd1 << arsize) - 33'd1;
   assign dec_err   = araddr < ADDR_BASE || last_byte >= {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
   assign req_resp  = bad_req ? 2'b10 : dec_err ? 2'b11 : 2'b00;
   assign nxt_addr  = fixed_q ? cur_addr : cur_addr + (32'd1 << size_q);
   assign last_beat = beat == len_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wcnt     <= 4'd0;
         beat     <= 8'd0;
         len_q    <= 8'd0;
         size_q   <= 3'd0;
         fixed_q  <= 1'b0;
         cur_addr <= 32'd0;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= 32'd0;
         rresp    <= 2'b00;
         rlast    <= 1'b0;
         rid      <= 4'd0;
         mem_en   <= 1'b0;
         mem_addr <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               arready <= 1'b1;
               if (arvalid && arready) begin
                  arready  <= 1'b0;
                  len_q    <= arlen;
                  size_q   <= arsize;
                  fixed_q  <= ~arburst[0];
                  cur_addr <= araddr;
                  beat     <= 8'd0;
                  wcnt     <= 4'd0;
                  rid      <= arid;
                  rresp    <= req_resp;
                  rdata    <= 32'd0;
                  if (req_resp != 2'b00) state <= DATA;
                  else if (LATENCY > 0) state <= WAIT;
                  else begin
                     state    <= FETCH;
                     mem_en   <= 1'b1;
                     mem_addr <= {araddr[31:2], 2'b00};
                  end
               end
            end
            WAIT: begin
               if (wcnt == LAT_LAST) begin
                  state    <= FETCH;
                  mem_en   <= 1'b1;
                  mem_addr <= {cur_addr[31:2], 2'b00};
               end else wcnt <= wcnt + 4'd1;
            end
            FETCH: begin
               mem_en <= 1'b0;
               state  <= LOAD;
            end
            LOAD: begin
               rdata  <= mem_rdata;
               rvalid <= 1'b1;
               rlast  <= last_beat;
               state  <= DATA;
            end
            DATA: begin
               // error bursts enter here with rvalid low, giving one cycle of response latency
               if (!rvalid) begin
                  rvalid <= 1'b1;
                  rlast  <= last_beat;
               end else if (rready) begin
                  if (last_beat) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     beat     <= beat + 8'd1;
                     cur_addr <= nxt_addr;
                     if (rresp != 2'b00) rlast <= beat + 8'd1 == len_q;
                     else begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        wcnt   <= 4'd0;
                        if (LATENCY > 0) state <= WAIT;
                        else begin
                           state    <= FETCH;
                           mem_en   <= 1'b1;
                           mem_addr <= {nxt_addr[31:2], 2'b00};
                        end
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_25020037_axi_rd_slave.sv
// tb_ysyx_25020037_axi_rd_slave: directed and randomized AXI read bursts checked against a request-level model
module tb_ysyx_25020037_axi_rd_slave;
   localparam logic [31:0] BASE = 32'hA0000000;
   localparam logic [31:0] SIZE = 32'h02000000;
   localparam int          LAT  = 0;
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          fb;
      int          fc;
   } case_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] araddr = 32'd0;
   logic [3:0]  arid = 4'd0;
   logic [7:0]  arlen = 8'd0;
   logic [2:0]  arsize = 3'd0;
   logic [1:0]  arburst = 2'b00;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = 32'd0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] got_data[$];
   logic [1:0]  got_resp[$];
   logic        got_last[$];
   logic [3:0]  got_id[$];
   logic [31:0] mem_log[$];
   int          first_lat;
   int          unstable;
   int          proto_bad;
   logic        tmo;
   logic        ar_after;

   ysyx_25020037_axi_rd_slave #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a == 32'hA0000010 ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A) * 32'h9E3779B1 + 32'h1357;
   endfunction

   always @(posedge clk) if (mem_en) mem_rdata <= memf(mem_addr);
   always @(negedge clk) if (mem_en) mem_log.push_back(mem_addr);

   function automatic case_t mk(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                input logic [2:0] sz, input logic [1:0] bu, input int fb, input int fc);
      case_t c;
      c.addr = a; c.id = id; c.len = len; c.size = sz; c.burst = bu; c.fb = fb; c.fc = fc;
      return c;
   endfunction

   function automatic case_t rand_case();
      case_t c;
      int    r;
      r = int'($urandom_range(9));
      c.addr = r < 6 ? BASE + 32'($urandom_range(1023)) * 32'd4
             : r < 8 ? BASE + SIZE - 32'($urandom_range(16)) * 32'd4 : $urandom;
      if ($urandom_range(5) == 0) c.addr[1:0] = 2'($urandom_range(3));
      c.id    = 4'($urandom);
      c.len   = $urandom_range(3) == 0 ? 8'($urandom_range(15)) : 8'($urandom_range(3));
      c.size  = $urandom_range(9) == 0 ? 3'd3 : 3'($urandom_range(2));
      c.burst = $urandom_range(9) == 0 ? 2'(2 + $urandom_range(1)) : 2'($urandom_range(1));
      c.fb    = -1;
      c.fc    = 0;
      return c;
   endfunction

   // response classification straight from the request's byte range
   function automatic logic [1:0] model_resp(input case_t c);
      longint unsigned nb, first, last;
      nb    = 64'd1 << c.size;
      first = 64'(c.addr);
      if (c.burst > 2'b01 || c.size > 3'd2 || first % nb != 0) return 2'b10;
      last = first + (c.burst == 2'b01 ? (64'(c.len) + 1) * nb : nb) - 1;
      if (first < 64'(BASE) || last >= 64'(BASE) + 64'(SIZE)) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [31:0] beat_word(input case_t c, input int i);
      logic [31:0] a;
      a = c.addr + (c.burst == 2'b01 ? 32'(i) << c.size : 32'd0);
      return {a[31:2], 2'b00};
   endfunction

   task automatic run_burst(input case_t c, input int stall_pct);
      int          k, beat, n, sc;
      logic        held;
      logic [31:0] hd;
      logic [1:0]  hr;
      logic        hl;
      logic [3:0]  hi;
      got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
      first_lat = -1; unstable = 0; proto_bad = 0; tmo = 1'b0; ar_after = 1'b0;
      held = 1'b0; beat = 0; sc = 0; k = 0; n = 0;
      hd = 32'd0; hr = 2'b00; hl = 1'b0; hi = 4'd0;
      @(negedge clk);
      mem_log.delete();
      araddr = c.addr; arid = c.id; arlen = c.len; arsize = c.size; arburst = c.burst; arvalid = 1'b1;
      while (!arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!arready) begin
         tmo = 1'b1;
         arvalid = 1'b0;
         return;
      end
      while (beat <= int'(c.len) && k < 4000) begin
         @(negedge clk);
         k++;
         arvalid = 1'b0;
         if (arready) proto_bad++;
         if (rvalid) begin
            if (first_lat < 0) first_lat = k - 1;
            if (held && (rdata !== hd || rresp !== hr || rlast !== hl || rid !== hi)) unstable++;
            hd = rdata; hr = rresp; hl = rlast; hi = rid;
            if ((beat == c.fb && sc < c.fc) || $urandom_range(99) < stall_pct) begin
               if (beat == c.fb) sc++;
               rready = 1'b0;
               held = 1'b1;
            end else begin
               rready = 1'b1;
               held = 1'b0;
               got_data.push_back(rdata); got_resp.push_back(rresp);
               got_last.push_back(rlast); got_id.push_back(rid);
               beat++;
            end
         end else begin
            if (held || rlast) proto_bad++;
            held = 1'b0;
            rready = 1'($urandom_range(1));
         end
      end
      if (beat <= int'(c.len)) tmo = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      ar_after = arready;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({arready, rvalid, rdata, rresp, rlast, rid, mem_en, mem_addr} !== 74'd0) begin
         errors++;
         $display("FAIL reset_values: got %h required 0", {arready, rvalid, rdata, rresp, rlast, rid, mem_en, mem_addr});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_arready: got %b required 1", arready);
      end
   endtask

   task automatic test_bursts;
      case_t       dir[12];
      case_t       c;
      logic [1:0]  er;
      logic [31:0] ed;
      int          nb, el, nm;
      dir[0]  = mk(32'hA0000010, 4'd1,  8'd0,   3'd2, 2'b01, -1, 0);
      dir[1]  = mk(32'hA0000000, 4'd2,  8'd3,   3'd2, 2'b01,  1, 2);
      dir[2]  = mk(32'hA0000020, 4'd3,  8'd2,   3'd2, 2'b00, -1, 0);
      dir[3]  = mk(32'h80000000, 4'd4,  8'd3,   3'd2, 2'b01, -1, 0);
      dir[4]  = mk(32'hA1FFFFFC, 4'd5,  8'd1,   3'd2, 2'b01, -1, 0);
      dir[5]  = mk(32'hA0000000, 4'd6,  8'd1,   3'd3, 2'b01, -1, 0);
      dir[6]  = mk(32'hA0000000, 4'd7,  8'd2,   3'd2, 2'b10, -1, 0);
      dir[7]  = mk(32'hA0000002, 4'd8,  8'd0,   3'd2, 2'b01, -1, 0);
      dir[8]  = mk(32'hA0000000, 4'd9,  8'd255, 3'd2, 2'b01, -1, 0);
      dir[9]  = mk(32'hA0000101, 4'd10, 8'd4,   3'd0, 2'b01,  2, 1);
      dir[10] = mk(32'hA1FFFFFE, 4'd11, 8'd9,   3'd1, 2'b00, -1, 0);
      dir[11] = mk(32'hA1FFFFFC, 4'd12, 8'd0,   3'd2, 2'b01, -1, 0);
      for (int t = 0; t < 52; t++) begin
         c = t < 12 ? dir[t] : rand_case();
         run_burst(c, t < 12 ? 0 : 30);
         er = model_resp(c);
         el = er == 2'b00 ? 2 + LAT : 1;
         nb = int'(c.len) + 1;
         checks++;
         if (tmo) begin
            errors++;
            $display("FAIL case%0d_timeout: beats %0d required %0d", t, got_data.size(), nb);
            continue;
         end
         checks++;
         if (first_lat != el) begin
            errors++;
            $display("FAIL case%0d_latency: got %0d required %0d", t, first_lat, el);
         end
         checks++;
         if (got_data.size() != nb) begin
            errors++;
            $display("FAIL case%0d_beats: got %0d required %0d", t, got_data.size(), nb);
         end
         for (int i = 0; i < nb && i < got_data.size(); i++) begin
            ed = er == 2'b00 ? memf(beat_word(c, i)) : 32'd0;
            checks++;
            if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == nb - 1) || got_id[i] !== c.id) begin
               errors++;
               $display("FAIL case%0d_beat%0d: data %h resp %b last %b id %h required %h %b %b %h",
                        t, i, got_data[i], got_resp[i], got_last[i], got_id[i], ed, er, i == nb - 1, c.id);
            end
         end
         nm = er == 2'b00 ? nb : 0;
         checks++;
         if (mem_log.size() != nm) begin
            errors++;
            $display("FAIL case%0d_mem_count: got %0d required %0d", t, mem_log.size(), nm);
         end
         for (int i = 0; i < nm && i < mem_log.size(); i++) begin
            checks++;
            if (mem_log[i] !== beat_word(c, i)) begin
               errors++;
               $display("FAIL case%0d_mem_addr%0d: got %h required %h", t, i, mem_log[i], beat_word(c, i));
            end
         end
         checks++;
         if (unstable != 0 || proto_bad != 0 || ar_after !== 1'b1) begin
            errors++;
            $display("FAIL case%0d_protocol: unstable %0d bad %0d arready_after %b required 0 0 1",
                     t, unstable, proto_bad, ar_after);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int k, seen, ml;
      @(negedge clk);
      araddr = 32'hA0000040; arid = 4'd12; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1; rready = 1'b1;
      k = 0; seen = 0;
      while (seen < 2 && k < 100) begin
         @(negedge clk);
         k++;
         arvalid = 1'b0;
         if (rvalid) seen++;
      end
      rready = 1'b0;
      checks++;
      if (seen < 2) begin
         errors++;
         $display("FAIL midrst_reach_beat2: beats seen %0d required 2", seen);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({arready, rvalid, rdata, rresp, rlast, rid, mem_en, mem_addr} !== 74'd0) begin
         errors++;
         $display("FAIL midrst_async_values: got %h required 0", {arready, rvalid, rdata, rresp, rlast, rid, mem_en, mem_addr});
      end
      ml = mem_log.size();
      repeat (3) @(negedge clk);
      checks++;
      if (mem_log.size() != ml || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet: mem accesses %0d rvalid %b required 0 0", mem_log.size() - ml, rvalid);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_arready: got %b required 1", arready);
      end
      run_burst(mk(32'hA0000010, 4'd3, 8'd0, 3'd2, 2'b01, -1, 0), 0);
      checks++;
      if (tmo || got_data.size() != 1 || mem_log.size() != 1) begin
         errors++;
         $display("FAIL midrst_after_count: timeout %b beats %0d mem %0d required 0 1 1", tmo, got_data.size(), mem_log.size());
      end else begin
         checks++;
         if (got_data[0] !== 32'hDEADBEEF || got_resp[0] !== 2'b00 || got_last[0] !== 1'b1 || got_id[0] !== 4'd3) begin
            errors++;
            $display("FAIL midrst_after_beat: data %h resp %b last %b id %h required deadbeef 00 1 3",
                     got_data[0], got_resp[0], got_last[0], got_id[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bursts();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
